// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 opcodes,
// FSM state encoding, and operand signedness decode.
// Imported by muldiv_sequencer and muldiv_divstep.
package muldiv_pkg;

    // funct3 encodings of the M-extension R-type ops
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_DIV  = ST_DIV,
        S_DONE = ST_DONE
    } state_t;

    // rs1 is two's complement for MUL, MULH, MULHSU, DIV, REM.
    // MUL's low word is identical either way; treating it as signed keeps
    // the magnitude/sign path uniform.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is two's complement for MUL, MULH, DIV, REM (MULHSU treats it unsigned)
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step on unsigned magnitudes (pure combinational).
// Latency: 0 cycles; the sequencer registers the outputs once per clock.
// Backpressure: none; it is a leaf function of its inputs.
// Ports: rem/quo/divisor in (quo carries the not-yet-consumed dividend bits
//        in its top and accumulated quotient bits in its bottom),
//        rem_next/quo_next out.
module muldiv_divstep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // rem < divisor always holds between steps, but the shifted value can need
    // one extra bit when an unsigned divisor is close to 2^XLEN.
    logic [XLEN:0]   rem_sh;
    logic            fits;
    logic [XLEN-1:0] diff;

    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        fits     = (rem_sh >= {1'b0, divisor});
        // When fits is set the true difference is below divisor, so the
        // XLEN-bit modular subtraction is exact.
        diff     = rem_sh[XLEN-1:0] - divisor;
        rem_next = fits ? diff : rem_sh[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Latency: o_valid XLEN+1 cycles after accept; divide-by-zero/overflow (and fast multiply) 1 cycle.
// Backpressure: o_ready only in IDLE; requests while busy are dropped, i_flush aborts back to IDLE.
// Ports: i_clk, i_rst_n (async active-low), i_valid/o_ready request handshake,
//        i_funct3 op select, i_op_a/i_op_b operands, i_flush abort,
//        o_busy (not IDLE), o_valid one-cycle result strobe, o_result held result.
// Build option: define MULDIV_FAST_MUL_EN to resolve multiplies with a
//        single-cycle combinational product; divides stay iterative.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int              CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [2:0]        f3_q;
    logic              neg_q;       // product / quotient must be negated
    logic              rem_neg_q;   // remainder takes the dividend's sign
    logic [2*XLEN-1:0] acc_q;       // product accumulator
    logic [2*XLEN-1:0] mcand_q;     // multiplicand, shifted left each step
    logic [XLEN-1:0]   opb_q;       // multiplier (shifted right) or divisor (static)
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   result_q;

    // ---------------------------------------------------------------
    // Accept-side decode: magnitudes, signs and single-cycle shortcuts
    // ---------------------------------------------------------------
    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, corner;
    logic [XLEN-1:0] corner_res;
    logic            fast_mul;
    logic [XLEN-1:0] fast_res;
    logic            shortcut;
    logic [XLEN-1:0] shortcut_res;

    always_comb begin
        sa    = is_signed_a(i_funct3) & i_op_a[XLEN-1];
        sb    = is_signed_b(i_funct3) & i_op_b[XLEN-1];
        mag_a = sa ? (~i_op_a + 1'b1) : i_op_a;
        mag_b = sb ? (~i_op_b + 1'b1) : i_op_b;

        div_zero = i_funct3[2] && (i_op_b == '0);
        // Only DIV/REM are signed among divide ops, so is_signed_a picks them out
        div_ovf  = i_funct3[2] && is_signed_a(i_funct3) &&
                   (i_op_a == MIN_VAL) && (i_op_b == '1);
        corner   = div_zero || div_ovf;

        // funct3[1] distinguishes REM* from DIV*. A zero divisor returns the
        // raw dividend as remainder, not its magnitude.
        if (div_zero) begin
            corner_res = i_funct3[1] ? i_op_a : '1;
        end else begin
            corner_res = i_funct3[1] ? '0 : MIN_VAL;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // One extra bit per operand lets a single signed multiply cover the
    // signed, unsigned and mixed-sign variants.
    logic signed [XLEN:0]     ext_a, ext_b;
    logic signed [2*XLEN+1:0] full_prod;
    logic [2*XLEN-1:0]        fast_prod;

    always_comb begin
        ext_a     = {is_signed_a(i_funct3) & i_op_a[XLEN-1], i_op_a};
        ext_b     = {is_signed_b(i_funct3) & i_op_b[XLEN-1], i_op_b};
        full_prod = ext_a * ext_b;
        fast_prod = full_prod[2*XLEN-1:0];
        fast_mul  = !i_funct3[2];
        fast_res  = (i_funct3 == F3_MUL) ? fast_prod[XLEN-1:0]
                                         : fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    always_comb begin
        shortcut     = corner || fast_mul;
        shortcut_res = corner ? corner_res : fast_res;
    end

    // ---------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] mul_acc_nxt;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   div_rem_nxt, div_quo_nxt;
    logic [XLEN-1:0]   quo_fin, rem_fin;
    logic [XLEN-1:0]   iter_res;

    muldiv_divstep #(
        .XLEN (XLEN)
    ) u_divstep (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (opb_q),
        .rem_next (div_rem_nxt),
        .quo_next (div_quo_nxt)
    );

    always_comb begin
        mul_acc_nxt = acc_q + (opb_q[0] ? mcand_q : '0);
        // Negate the whole double-width product so the high word borrows correctly
        prod_fin    = neg_q ? (~mul_acc_nxt + 1'b1) : mul_acc_nxt;
        quo_fin     = neg_q ? (~div_quo_nxt + 1'b1) : div_quo_nxt;
        rem_fin     = rem_neg_q ? (~div_rem_nxt + 1'b1) : div_rem_nxt;

        if (state_q == S_MUL) begin
            iter_res = (f3_q == F3_MUL) ? prod_fin[XLEN-1:0]
                                        : prod_fin[2*XLEN-1:XLEN];
        end else begin
            iter_res = f3_q[1] ? rem_fin : quo_fin;
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    logic accept;
    logic iterate;
    logic last_iter;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        iterate   = 1'b0;
        last_iter = 1'b0;
        o_ready   = 1'b0;
        o_busy    = 1'b1;
        o_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                // A flush in the same cycle as a request squashes it
                if (i_valid && !i_flush) begin
                    accept = 1'b1;
                    if (shortcut) begin
                        state_nxt = S_DONE;
                    end else if (i_funct3[2]) begin
                        state_nxt = S_DIV;
                    end else begin
                        state_nxt = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (i_flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    iterate = 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        last_iter = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The strobe stands even if flushed this cycle; IDLE follows regardless
                o_valid   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q   <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            f3_q      <= i_funct3;
            neg_q     <= sa ^ sb;
            rem_neg_q <= sa;
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, mag_a};
            opb_q     <= mag_b;
            rem_q     <= '0;
            // Dividend bits are consumed from the top of quo_q as quotient
            // bits enter at the bottom.
            quo_q     <= mag_a;
            if (shortcut) begin
                count_q  <= '0;
                result_q <= shortcut_res;
            end else begin
                count_q  <= CNT_W'(XLEN);
            end
        end else if (iterate) begin
            count_q <= count_q - 1'b1;
            if (state_q == S_MUL) begin
                acc_q   <= mul_acc_nxt;
                mcand_q <= mcand_q << 1;
                opb_q   <= opb_q >> 1;
            end else begin
                rem_q <= div_rem_nxt;
                quo_q <= div_quo_nxt;
            end
            if (last_iter) begin
                result_q <= iter_res;
            end
        end else begin
            // Parked at zero outside the iterating states (also after a flush)
            count_q <= '0;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (XLEN=32).
// Latency: expected o_valid latency is counted in clock edges after the accept edge.
// Backpressure: requests are only launched when the DUT should be IDLE.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int LAT_ITER   = 33;
    localparam int LAT_CORNER = 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = LAT_ITER;
`endif

    logic        i_clk    = 1'b0;
    logic        i_rst_n  = 1'b1;
    logic        i_valid  = 1'b0;
    logic        i_flush  = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_op_a   = '0;
    logic [31:0] i_op_b   = '0;
    logic        o_ready, o_busy, o_valid;
    logic [31:0] o_result;

    muldiv_sequencer #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference results from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          si, sj;
        logic [31:0] r;
        si = a;
        sj = b;
        r  = '0;
        p  = '0;
        case (f3)
            F3_MUL:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0];  end
            F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};       r = p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b};             r = p[63:32]; end
            F3_DIV:    r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : si / sj;
            F3_REM:    r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : si % sj;
            F3_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return LAT_MUL;
        if (b == 0) return LAT_CORNER;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return LAT_CORNER;
        return LAT_ITER;
    endfunction

    // Drive one request for a single cycle and record what must come back
    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        exp_t e;
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_op_a   = a;
        i_op_b   = b;
        e.res    = exp_res;
        e.lat    = exp_lat(f3, a, b);
        sb.push_back(e);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    // Sample at falling edges until o_valid, bounded
    task automatic wait_valid(input int start, output logic [31:0] res, output int lat, output bit timeout);
        res     = '0;
        lat     = 0;
        timeout = 1'b1;
        for (int k = start + 1; k <= start + 200; k++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                res     = o_result;
                lat     = k;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", o_result); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", o_ready); end
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat; bit to; exp_t e;
        send_req(F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        wait_valid(0, res, lat, to);
        e = sb.pop_front();
        n_cmp++;
        if (to) begin n_err++; $display("FAIL mul timeout: no o_valid, expected %h", e.res); end
        else begin
            if (res !== e.res) begin n_err++; $display("FAIL mul result: got %h expected %h", res, e.res); end
            n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL mul latency: got %0d expected %0d", lat, e.lat); end
            @(negedge i_clk);
            n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mul strobe_width: o_valid %b expected 0", o_valid); end
            n_cmp++; if (o_result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul hold: got %h expected ffffffeb", o_result); end
        end
    endtask

    task automatic test_mulh();
        logic [2:0] f3[3]; logic [31:0] a[3], b[3], ex[3];
        logic [31:0] res; int lat; bit to; exp_t e;
        f3 = '{F3_MULH, F3_MULHU, F3_MULHSU};
        a  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        b  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ex = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            send_req(f3[i], a[i], b[i], ex[i]);
            wait_valid(0, res, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin n_err++; $display("FAIL mulh[%0d] timeout: no o_valid, expected %h", i, e.res); end
            else begin
                if (res !== e.res) begin n_err++; $display("FAIL mulh[%0d] result: got %h expected %h", i, res, e.res); end
                n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL mulh[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_div();
        logic [2:0] f3[4]; logic [31:0] a[4], b[4], ex[4];
        logic [31:0] res; int lat; bit to; exp_t e;
        f3 = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        a  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        b  = '{32'd2, 32'd2, 32'd7, 32'd7};
        ex = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            send_req(f3[i], a[i], b[i], ex[i]);
            wait_valid(0, res, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin n_err++; $display("FAIL div[%0d] timeout: no o_valid, expected %h", i, e.res); end
            else begin
                if (res !== e.res) begin n_err++; $display("FAIL div[%0d] result: got %h expected %h", i, res, e.res); end
                n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_corner();
        logic [2:0] f3[4]; logic [31:0] a[4], b[4], ex[4];
        logic [31:0] res; int lat; bit to; exp_t e;
        f3 = '{F3_DIV, F3_REM, F3_DIV, F3_REM};
        a  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        b  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ex = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            send_req(f3[i], a[i], b[i], ex[i]);
            wait_valid(0, res, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin n_err++; $display("FAIL corner[%0d] timeout: no o_valid, expected %h", i, e.res); end
            else begin
                if (res !== e.res) begin n_err++; $display("FAIL corner[%0d] result: got %h expected %h", i, res, e.res); end
                n_cmp++; if (lat !== LAT_CORNER) begin n_err++; $display("FAIL corner[%0d] latency: got %0d expected %0d", i, lat, LAT_CORNER); end
            end
        end
        // Flush raised while DONE: the strobe in that cycle still stands
        send_req(F3_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF);
        e = sb.pop_front();
        @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL flush_done valid: got %b expected 1", o_valid); end
        n_cmp++; if (o_result !== e.res) begin n_err++; $display("FAIL flush_done result: got %h expected %h", o_result, e.res); end
        i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL flush_done after: valid %b ready %b expected 0 1", o_valid, o_ready); end
    endtask

    task automatic test_flush();
        logic [31:0] res; int lat; bit to; exp_t e; bit saw;
        // Flush together with a request in IDLE: request is dropped
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = F3_MUL; i_op_a = 32'd2; i_op_b = 32'd2;
        @(posedge i_clk);
        #1 begin i_valid = 1'b0; i_flush = 1'b0; end
        @(negedge i_clk);
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL flush_idle busy: got %b expected 0", o_busy); end

        // Extra request pulse while busy must be ignored
        send_req(F3_DIVU, 32'd100, 32'd7, 32'd14);
        repeat (5) @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = F3_MUL; i_op_a = 32'd2; i_op_b = 32'd2;
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_valid(6, res, lat, to);
        e = sb.pop_front();
        n_cmp++;
        if (to) begin n_err++; $display("FAIL busy_ignore timeout: no o_valid, expected %h", e.res); end
        else begin
            if (res !== e.res) begin n_err++; $display("FAIL busy_ignore result: got %h expected %h", res, e.res); end
            n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL busy_ignore latency: got %0d expected %0d", lat, e.lat); end
        end
        @(negedge i_clk);
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL busy_ignore idle: busy %b expected 0", o_busy); end

        // Flush at T+10 of a DIV
        send_req(F3_DIV, 32'd1000, 32'd3, 32'd333);
        void'(sb.pop_back());
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL flush ready_T11: got %b expected 1", o_ready); end
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) saw = 1'b1;
        end
        n_cmp++; if (saw) begin n_err++; $display("FAIL flush no_valid: o_valid seen after flush, expected none"); end
        n_cmp++; if (o_result !== 32'd14) begin n_err++; $display("FAIL flush result_kept: got %h expected 0000000e", o_result); end

        send_req(F3_MUL, 32'd3, 32'd4, 32'd12);
        wait_valid(0, res, lat, to);
        e = sb.pop_front();
        n_cmp++;
        if (to) begin n_err++; $display("FAIL post_flush_mul timeout: no o_valid, expected %h", e.res); end
        else if (res !== e.res) begin n_err++; $display("FAIL post_flush_mul result: got %h expected %h", res, e.res); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res; int lat; bit to; exp_t e;
        send_req(F3_DIVU, 32'd50, 32'd5, 32'd10);
        void'(sb.pop_back());
        repeat (4) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL arst busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_result !== 32'h0) begin n_err++; $display("FAIL arst result: got %h expected 00000000", o_result); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_req(F3_DIVU, 32'd9, 32'd3, 32'd3);
        wait_valid(0, res, lat, to);
        e = sb.pop_front();
        n_cmp++;
        if (to) begin n_err++; $display("FAIL arst_divu timeout: no o_valid, expected %h", e.res); end
        else begin
            if (res !== e.res) begin n_err++; $display("FAIL arst_divu result: got %h expected %h", res, e.res); end
            n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL arst_divu latency: got %0d expected %0d", lat, e.lat); end
        end
    endtask

    // Random ops issued at the earliest legal cycle after each result
    task automatic test_back_to_back();
        logic [31:0] res; int lat; bit to; exp_t e;
        logic [2:0] f3; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case (i % 4)
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if (i == 6) a = 32'h80000000;
            send_req(f3, a, b, ref_model(f3, a, b));
            wait_valid(0, res, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin n_err++; $display("FAIL b2b[%0d] timeout: f3 %0d no o_valid, expected %h", i, f3, e.res); end
            else begin
                if (res !== e.res) begin n_err++; $display("FAIL b2b[%0d] result: f3 %0d a %h b %h got %h expected %h", i, f3, a, b, res, e.res); end
                n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
                n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL b2b[%0d] ready_in_done: got %b expected 0", i, o_ready); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_corner();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
